// File: rtl/canvas_mem_arbiter_pkg.sv
// Shared geometry, pixel format and FSM encoding for the canvas BRAM arbiter.
package canvas_mem_arbiter_pkg;

  localparam int CANVAS_X0    = 160;
  localparam int CANVAS_Y0    = 120;
  localparam int CANVAS_W     = 80;
  localparam int CANVAS_H     = 60;
  localparam int SCALE_SHIFT  = 2;
  localparam int CANVAS_CELLS = CANVAS_W * CANVAS_H;
  localparam int CANVAS_PX_W  = CANVAS_W << SCALE_SHIFT;
  localparam int CANVAS_PX_H  = CANVAS_H << SCALE_SHIFT;
  localparam int ADDR_W       = 13;
  localparam int PIX_W        = 12;

  localparam logic [PIX_W-1:0] CLEAR_COLOR  = 12'hFFF;
  localparam logic [PIX_W-1:0] BORDER_COLOR = 12'h000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] cy, input logic [6:0] cx);
    return ADDR_W'(cy) * ADDR_W'(CANVAS_W) + ADDR_W'(cx);
  endfunction

endpackage

// File: rtl/canvas_mem_arbiter_addr_map.sv
// Combinational map from VGA h/v counts to canvas cell address and read-slot flag.
// Ring border test is built only when CANVAS_BORDER_EN is defined.
module canvas_addr_map
  import canvas_mem_arbiter_pkg::*;
(
  input  logic              i_valid,
  input  logic [9:0]        i_h_cnt,
  input  logic [9:0]        i_v_cnt,
  output logic              o_in_canvas,
  output logic              o_read_slot,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_border
);

  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic [6:0] w_cx;
  logic [5:0] w_cy;
  logic       w_in_x;
  logic       w_in_y;

  assign w_dx   = i_h_cnt - 10'(CANVAS_X0);
  assign w_dy   = i_v_cnt - 10'(CANVAS_Y0);
  assign w_in_x = (i_h_cnt >= 10'(CANVAS_X0)) && (i_h_cnt < 10'(CANVAS_X0 + CANVAS_PX_W));
  assign w_in_y = (i_v_cnt >= 10'(CANVAS_Y0)) && (i_v_cnt < 10'(CANVAS_Y0 + CANVAS_PX_H));
  assign w_cx   = 7'(w_dx >> SCALE_SHIFT);
  assign w_cy   = 6'(w_dy >> SCALE_SHIFT);

  assign o_in_canvas = i_valid && w_in_x && w_in_y;
  // One BRAM read per cell, on its leftmost screen pixel.
  assign o_read_slot = o_in_canvas && (w_dx[SCALE_SHIFT-1:0] == '0);
  assign o_addr      = cell_addr(w_cy, w_cx);

`ifdef CANVAS_BORDER_EN
  logic w_ring_x;
  logic w_ring_y;

  assign w_ring_x = (i_h_cnt >= 10'(CANVAS_X0 - 1)) && (i_h_cnt <= 10'(CANVAS_X0 + CANVAS_PX_W));
  assign w_ring_y = (i_v_cnt >= 10'(CANVAS_Y0 - 1)) && (i_v_cnt <= 10'(CANVAS_Y0 + CANVAS_PX_H));
  assign o_border = i_valid && w_ring_x && w_ring_y && !o_in_canvas;
`else
  assign o_border = 1'b0;
`endif

endmodule

// File: rtl/canvas_mem_arbiter.sv
// Single-port canvas BRAM arbiter: scan-out reads, clear engine and brush writes.
// Optional one-pixel border ring is enabled with CANVAS_BORDER_EN.
//
// state    | meaning
// ST_IDLE  | brush writes accepted in free slots
// ST_CLEAR | clear engine writes CLEAR_COLOR over every cell, brush held off
module canvas_mem_arbiter
  import canvas_mem_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [9:0]        i_h_cnt,
  input  logic [9:0]        i_v_cnt,
  input  logic              i_draw_req,
  input  logic [6:0]        i_draw_x,
  input  logic [5:0]        i_draw_y,
  input  logic [PIX_W-1:0]  i_draw_color,
  output logic              o_draw_ack,
  input  logic              i_clear_req,
  output logic              o_clear_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [PIX_W-1:0]  o_mem_wdata,
  input  logic [PIX_W-1:0]  i_mem_rdata,
  output logic              o_canvas_enable,
  output logic [PIX_W-1:0]  o_canvas_pixel
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              r_s1_en;
  logic              r_s1_slot;
  logic              r_s1_border;
  logic [PIX_W-1:0]  r_cell;
  logic              r_en;
  logic [PIX_W-1:0]  r_pix;

  logic              w_in_canvas;
  logic              w_read_slot;
  logic              w_border;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_draw_in_range;
  logic              w_clr_last;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [PIX_W-1:0]  w_mem_wdata;
  logic              w_draw_ack;

  canvas_addr_map u_addr_map (
    .i_valid     (i_valid),
    .i_h_cnt     (i_h_cnt),
    .i_v_cnt     (i_v_cnt),
    .o_in_canvas (w_in_canvas),
    .o_read_slot (w_read_slot),
    .o_addr      (w_scan_addr),
    .o_border    (w_border)
  );

  assign w_draw_in_range = (i_draw_x < 7'(CANVAS_W)) && (i_draw_y < 6'(CANVAS_H));
  assign w_clr_last      = (r_clr_addr == ADDR_W'(CANVAS_CELLS - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_mem_addr     = w_read_slot ? w_scan_addr : '0;
    w_mem_we       = 1'b0;
    w_mem_wdata    = '0;
    w_draw_ack     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clear_req) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_addr_nxt = '0;
        end else if (i_draw_req && !w_read_slot) begin
          w_draw_ack = 1'b1;
          // Off-canvas brush coordinates are consumed without touching memory.
          if (w_draw_in_range) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = cell_addr(i_draw_y, i_draw_x);
            w_mem_wdata = i_draw_color;
          end
        end
      end
      ST_CLEAR: begin
        if (i_clear_req) begin
          w_clr_addr_nxt = '0;
        end else if (!w_read_slot) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_clr_addr;
          w_mem_wdata = CLEAR_COLOR;
          if (w_clr_last) begin
            w_state_nxt    = ST_IDLE;
            w_clr_addr_nxt = '0;
          end else begin
            w_clr_addr_nxt = r_clr_addr + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Keep the BRAM port and handshake quiet while reset is held.
    if (i_rst) begin
      w_mem_addr  = '0;
      w_mem_we    = 1'b0;
      w_mem_wdata = '0;
      w_draw_ack  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_clr_addr  <= '0;
      r_s1_en     <= 1'b0;
      r_s1_slot   <= 1'b0;
      r_s1_border <= 1'b0;
      r_cell      <= '0;
      r_en        <= 1'b0;
      r_pix       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_s1_en     <= w_in_canvas;
      r_s1_slot   <= w_read_slot;
      r_s1_border <= w_border;
      if (r_s1_slot) r_cell <= i_mem_rdata;
      r_en <= r_s1_en || r_s1_border;
      if (r_s1_en)          r_pix <= r_s1_slot ? i_mem_rdata : r_cell;
      else if (r_s1_border) r_pix <= BORDER_COLOR;
      else                  r_pix <= '0;
    end
  end

  assign o_mem_addr      = w_mem_addr;
  assign o_mem_we        = w_mem_we;
  assign o_mem_wdata     = w_mem_wdata;
  assign o_draw_ack      = w_draw_ack;
  assign o_clear_busy    = (r_state == ST_CLEAR);
  assign o_canvas_enable = r_en;
  assign o_canvas_pixel  = r_pix;

endmodule

// File: tb/tb_canvas_mem_arbiter.sv
// Self-checking bench for canvas_mem_arbiter with a behavioural BRAM and canvas model.
module tb_canvas_mem_arbiter;
  import canvas_mem_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              draw_req;
  logic [6:0]        draw_x;
  logic [5:0]        draw_y;
  logic [PIX_W-1:0]  draw_color;
  logic              draw_ack;
  logic              clear_req;
  logic              clear_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;
  logic              canvas_enable;
  logic [PIX_W-1:0]  canvas_pixel;

  always #5 clk = ~clk;

  canvas_mem_arbiter u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_h_cnt(h_cnt), .i_v_cnt(v_cnt),
    .i_draw_req(draw_req), .i_draw_x(draw_x), .i_draw_y(draw_y), .i_draw_color(draw_color),
    .o_draw_ack(draw_ack), .i_clear_req(clear_req), .o_clear_busy(clear_busy),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_canvas_enable(canvas_enable), .o_canvas_pixel(canvas_pixel)
  );

  // Behavioural single-port BRAM, read-first, one-cycle read latency.
  logic [PIX_W-1:0] bram [0:8191];
  logic             pl_we = 1'b0;
  logic [12:0]      pl_addr = '0;
  logic [PIX_W-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_we) bram[pl_addr] <= pl_data;
    else if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [PIX_W-1:0] ref_mem [0:CANVAS_CELLS-1];
  logic [PIX_W-1:0] last_rd = '0;
  bit chk_cv = 1'b1;
  typedef struct { bit chk; logic en; logic [PIX_W-1:0] pix; } cv_t;
  cv_t cv_q[$];
  bit cur_vl, cur_rs, cur_dreq;
  int cur_h, cur_v, cur_dx, cur_dy;
  logic [PIX_W-1:0] cur_col;

  localparam int CELL = 1 << SCALE_SHIFT;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_in(bit vl, int h, int v);
    return vl && h >= CANVAS_X0 && h < CANVAS_X0 + CANVAS_W * CELL &&
           v >= CANVAS_Y0 && v < CANVAS_Y0 + CANVAS_H * CELL;
  endfunction
  function automatic bit m_slot(bit vl, int h, int v);
    return m_in(vl, h, v) && ((h - CANVAS_X0) % CELL == 0);
  endfunction
  function automatic int m_addr(int h, int v);
    return ((v - CANVAS_Y0) / CELL) * CANVAS_W + (h - CANVAS_X0) / CELL;
  endfunction
`ifdef CANVAS_BORDER_EN
  function automatic bit m_ring(bit vl, int h, int v);
    return vl && h >= CANVAS_X0 - 1 && h <= CANVAS_X0 + CANVAS_W * CELL &&
           v >= CANVAS_Y0 - 1 && v <= CANVAS_Y0 + CANVAS_H * CELL && !m_in(vl, h, v);
  endfunction
`endif

  task automatic set_in(input bit vl, input int h, input int v, input bit dreq, input int dx,
                        input int dy, input logic [PIX_W-1:0] col, input bit creq, input bit rs);
    valid = vl; h_cnt = 10'(h); v_cnt = 10'(v);
    draw_req = dreq; draw_x = 7'(dx); draw_y = 6'(dy); draw_color = col;
    clear_req = creq; rst = rs;
    cur_vl = vl; cur_h = h; cur_v = v; cur_dreq = dreq; cur_dx = dx; cur_dy = dy;
    cur_col = col; cur_rs = rs;
    #1;
  endtask

  task automatic quiet(input bit creq, input bit rs);
    set_in(1'b0, 0, 0, 1'b0, 0, 0, '0, creq, rs);
  endtask

  // Canvas output expectation for the current pixel, compared two clocks later.
  task automatic tick();
    cv_t e;
    if (!cur_rs) begin
      e.chk = chk_cv; e.en = 1'b0; e.pix = '0;
      if (m_in(cur_vl, cur_h, cur_v)) begin
        if (m_slot(cur_vl, cur_h, cur_v)) last_rd = ref_mem[m_addr(cur_h, cur_v)];
        e.en = 1'b1; e.pix = last_rd;
      end
`ifdef CANVAS_BORDER_EN
      else if (m_ring(cur_vl, cur_h, cur_v)) begin
        e.en = 1'b1; e.pix = BORDER_COLOR;
      end
`endif
      cv_q.push_back(e);
    end
    @(posedge clk); #1;
    if (cur_rs) begin
      cv_q.delete();
      last_rd = '0;
    end else if (cv_q.size() == 2) begin
      e = cv_q.pop_front();
      if (e.chk) begin
        check("canvas_enable", 32'(canvas_enable), 32'(e.en));
        check("canvas_pixel", 32'(canvas_pixel), 32'(e.pix));
      end
    end
  endtask

  // Idle-state brush arbitration rule applied to the current inputs.
  task automatic chk_idle(input string tag);
    bit slot, e_ack, e_we;
    slot  = m_slot(cur_vl, cur_h, cur_v);
    e_ack = cur_dreq && !slot;
    e_we  = e_ack && cur_dx < CANVAS_W && cur_dy < CANVAS_H;
    check({tag, "_ack"}, 32'(draw_ack), 32'(e_ack));
    check({tag, "_we"}, 32'(mem_we), 32'(e_we));
    if (slot) begin
      check({tag, "_rd_addr"}, 32'(mem_addr), 32'(m_addr(cur_h, cur_v)));
    end else if (e_we) begin
      check({tag, "_wr_addr"}, 32'(mem_addr), 32'(cur_dy * CANVAS_W + cur_dx));
      check({tag, "_wdata"}, 32'(mem_wdata), 32'(cur_col));
      ref_mem[cur_dy * CANVAS_W + cur_dx] = cur_col;
    end
  endtask

  typedef struct {
    bit vl; int h; int v; bit dreq; int dx; int dy; logic [PIX_W-1:0] col;
    bit e_ack; bit e_we; bit c_addr; int e_addr; logic [PIX_W-1:0] e_wdata;
  } tv_t;
  tv_t tv[12];

  int sh = 156, sv = 116;
  task automatic adv_scan();
    sh++;
    if (sh > 483) begin
      sh = 156; sv++;
      if (sv > 363) sv = 116;
    end
  endtask

  int clr_cnt [0:CANVAS_CELLS-1];

  initial begin
    int n_wr, bad, ack_busy, not_once, first_addr, g;
    bit prev_last, got, found;

    tv[0]  = '{1'b0,   0,   0, 1'b1,  5,  3, 12'hF00, 1'b1, 1'b1, 1'b1,  245, 12'hF00};
    tv[1]  = '{1'b1, 160, 120, 1'b1,  5,  3, 12'hF00, 1'b0, 1'b0, 1'b1,    0, 12'h000};
    tv[2]  = '{1'b1, 161, 120, 1'b1,  1,  1, 12'hABC, 1'b1, 1'b1, 1'b1,   81, 12'hABC};
    tv[3]  = '{1'b0, 300, 300, 1'b1, 80,  0, 12'h123, 1'b1, 1'b0, 1'b0,    0, 12'h000};
    tv[4]  = '{1'b1, 100, 100, 1'b1,  0, 60, 12'h456, 1'b1, 1'b0, 1'b0,    0, 12'h000};
    tv[5]  = '{1'b1, 479, 359, 1'b1, 79, 59, 12'h789, 1'b1, 1'b1, 1'b1, 4799, 12'h789};
    tv[6]  = '{1'b1, 476, 359, 1'b1, 79, 59, 12'h789, 1'b0, 1'b0, 1'b1, 4799, 12'h000};
    tv[7]  = '{1'b1, 480, 200, 1'b1,  2,  0, 12'h3C3, 1'b1, 1'b1, 1'b1,    2, 12'h3C3};
    tv[8]  = '{1'b0, 160, 120, 1'b1,  3,  0, 12'h5A5, 1'b1, 1'b1, 1'b1,    3, 12'h5A5};
    tv[9]  = '{1'b1, 164, 124, 1'b0,  0,  0, 12'h000, 1'b0, 1'b0, 1'b1,   81, 12'h000};
    tv[10] = '{1'b1, 163, 120, 1'b0,  0,  0, 12'h000, 1'b0, 1'b0, 1'b0,    0, 12'h000};
    tv[11] = '{1'b1, 168, 121, 1'b1,  6,  2, 12'h0AA, 1'b0, 1'b0, 1'b1,    2, 12'h000};

    // Reset with BRAM preload; BRAM[0] carries the known scan colour.
    quiet(1'b0, 1'b1);
    pl_we = 1'b1;
    for (int a = 0; a < CANVAS_CELLS; a++) begin
      pl_addr = 13'(a);
      pl_data = (a == 0) ? 12'h0F0 : 12'($urandom);
      ref_mem[a] = pl_data;
      @(posedge clk); #1;
    end
    pl_we = 1'b0;
    set_in(1'b0, 0, 0, 1'b1, 5, 3, 12'hF00, 1'b1, 1'b1);
    check("rst_ack", 32'(draw_ack), 0);
    check("rst_we", 32'(mem_we), 0);
    tick();
    quiet(1'b0, 1'b0);
    check("rst_busy", 32'(clear_busy), 0);
    check("rst_en", 32'(canvas_enable), 0);
    check("rst_pix", 32'(canvas_pixel), 0);
    check("rst_addr", 32'(mem_addr), 0);
    tick();

    for (int i = 0; i < 12; i++) begin
      set_in(tv[i].vl, tv[i].h, tv[i].v, tv[i].dreq, tv[i].dx, tv[i].dy, tv[i].col, 1'b0, 1'b0);
      check($sformatf("tv%0d_ack", i), 32'(draw_ack), 32'(tv[i].e_ack));
      check($sformatf("tv%0d_we", i), 32'(mem_we), 32'(tv[i].e_we));
      if (tv[i].c_addr) check($sformatf("tv%0d_addr", i), 32'(mem_addr), 32'(tv[i].e_addr));
      if (tv[i].e_we) begin
        check($sformatf("tv%0d_wdata", i), 32'(mem_wdata), 32'(tv[i].e_wdata));
        ref_mem[tv[i].e_addr] = tv[i].e_wdata;
      end
      tick();
    end

    // Scan of cell 0: visible exactly two clocks later, held across its 4 pixels.
    quiet(1'b0, 1'b0); tick();
    quiet(1'b0, 1'b0); tick();
    set_in(1'b1, 160, 120, 1'b0, 0, 0, '0, 1'b0, 1'b0); tick();
    check("scan_not_early", 32'(canvas_enable), 0);
    set_in(1'b1, 161, 120, 1'b0, 0, 0, '0, 1'b0, 1'b0); tick();
    check("scan_lat2_en", 32'(canvas_enable), 1);
    check("scan_lat2_pix", 32'(canvas_pixel), 32'h0F0);
    set_in(1'b1, 162, 120, 1'b0, 0, 0, '0, 1'b0, 1'b0); tick();
    set_in(1'b1, 163, 120, 1'b0, 0, 0, '0, 1'b0, 1'b0); tick();
    set_in(1'b1, 164, 120, 1'b0, 0, 0, '0, 1'b0, 1'b0); tick();
    check("scan_hold_163", 32'(canvas_pixel), 32'h0F0);

    // Brush on a read slot waits for the next free slot.
    set_in(1'b1, 164, 124, 1'b1, 7, 7, 12'h246, 1'b0, 1'b0);
    check("slot_block_ack", 32'(draw_ack), 0);
    chk_idle("slot_block");
    tick();
    set_in(1'b1, 165, 124, 1'b1, 7, 7, 12'h246, 1'b0, 1'b0);
    check("slot_retry_ack", 32'(draw_ack), 1);
    chk_idle("slot_retry");
    tick();

    for (int i = 0; i < 1500; i++) begin
      set_in(($urandom % 10) != 0, 150 + int'($urandom % 345), 110 + int'($urandom % 260),
             1'($urandom), int'($urandom % 86), int'($urandom % 64), 12'($urandom), 1'b0, 1'b0);
      chk_idle("rnd");
      tick();
    end

    // Full clear under scan traffic with a brush request held throughout.
    chk_cv = 1'b0;
    n_wr = 0; bad = 0; ack_busy = 0; prev_last = 1'b0; g = 0;
    set_in(1'b1, sh, sv, 1'b1, 10, 10, 12'hABC, 1'b1, 1'b0);
    check("clr_vs_draw_ack", 32'(draw_ack), 0);
    check("clr_busy_pre", 32'(clear_busy), 0);
    tick(); adv_scan();
    check("clr_busy_rise", 32'(clear_busy), 1);
    while (g < 20000) begin
      set_in(1'b1, sh, sv, 1'b1, 10, 10, 12'hABC, 1'b0, 1'b0);
      if (!clear_busy) break;
      if (draw_ack) ack_busy++;
      prev_last = 1'b0;
      if (mem_we) begin
        n_wr++;
        if (mem_wdata != CLEAR_COLOR) bad++;
        if (int'(mem_addr) < CANVAS_CELLS) clr_cnt[mem_addr]++;
        else bad++;
        if (int'(mem_addr) == CANVAS_CELLS - 1) prev_last = 1'b1;
      end
      tick(); adv_scan(); g++;
    end
    check("clear_finished", 32'(clear_busy), 0);
    check("clear_writes", 32'(n_wr), 32'(CANVAS_CELLS));
    not_once = 0;
    for (int a = 0; a < CANVAS_CELLS; a++) if (clr_cnt[a] != 1) not_once++;
    check("clear_each_once", 32'(not_once), 0);
    check("clear_data", 32'(bad), 0);
    check("draw_held_in_clear", 32'(ack_busy), 0);
    check("busy_drop_after_last", 32'(prev_last), 1);
    for (int a = 0; a < CANVAS_CELLS; a++) ref_mem[a] = CLEAR_COLOR;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      if (draw_ack) begin
        got = 1'b1;
        check("draw_after_clear_we", 32'(mem_we), 1);
        check("draw_after_clear_addr", 32'(mem_addr), 810);
        check("draw_after_clear_wdata", 32'(mem_wdata), 32'hABC);
      end
      tick(); adv_scan();
      set_in(1'b1, sh, sv, !got, 10, 10, 12'hABC, 1'b0, 1'b0);
    end
    check("draw_after_clear", 32'(got), 1);

    // Restart mid-clear, then reset mid-clear.
    quiet(1'b1, 1'b0); tick();
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      quiet(1'b0, 1'b0);
      if (mem_we && mem_addr == 13'd1999) found = 1'b1;
      tick();
    end
    check("reach_1999", 32'(found), 1);
    quiet(1'b1, 1'b0); tick();
    found = 1'b0; first_addr = -1;
    for (int k = 0; k < 10 && !found; k++) begin
      quiet(1'b0, 1'b0);
      if (mem_we) begin found = 1'b1; first_addr = int'(mem_addr); end
      tick();
    end
    check("restart_addr0", 32'(first_addr), 0);
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      quiet(1'b0, 1'b0);
      if (mem_we && mem_addr == 13'd2999) found = 1'b1;
      tick();
    end
    check("reach_2999", 32'(found), 1);
    quiet(1'b0, 1'b1); tick();
    quiet(1'b0, 1'b0);
    check("post_rst_busy", 32'(clear_busy), 0);
    check("post_rst_ack", 32'(draw_ack), 0);
    check("post_rst_we", 32'(mem_we), 0);
    check("post_rst_addr", 32'(mem_addr), 0);
    check("post_rst_wdata", 32'(mem_wdata), 0);
    check("post_rst_en", 32'(canvas_enable), 0);
    check("post_rst_pix", 32'(canvas_pixel), 0);
    for (int a = 0; a < 3000; a++) ref_mem[a] = CLEAR_COLOR;
    chk_cv = 1'b1;
    tick();
    set_in(1'b0, 0, 0, 1'b1, 4, 0, 12'h0C0, 1'b0, 1'b0);
    chk_idle("post_rst_draw");
    tick();

    // Ring pixel just left of the canvas.
    set_in(1'b1, 159, 130, 1'b0, 0, 0, '0, 1'b0, 1'b0); tick();
    quiet(1'b0, 1'b0); tick();
`ifdef CANVAS_BORDER_EN
    check("border_en", 32'(canvas_enable), 1);
    check("border_pix", 32'(canvas_pixel), 32'(BORDER_COLOR));
`else
    check("no_border_en", 32'(canvas_enable), 0);
    check("no_border_pix", 32'(canvas_pixel), 0);
`endif
    set_in(1'b1, 480, 360, 1'b0, 0, 0, '0, 1'b0, 1'b0); tick();
    quiet(1'b0, 1'b0); tick();
    quiet(1'b0, 1'b0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/canvas_mem_arbiter.md
Name: canvas_mem_arbiter

Overview:
Owns the single-port canvas BRAM and shares it between three requesters: VGA scan-out reads, brush writes from the drawing logic, and an internal clear engine. It produces the canvas_enable / canvas_pixel pair consumed by the layer compositor. Scan-out reads always win. Writes only use slots that scan-out leaves free.

Parameters:
CANVAS_X0, 160, screen x of canvas left edge
CANVAS_Y0, 120, screen y of canvas top edge
CANVAS_W, 80, canvas width in cells
CANVAS_H, 60, canvas height in cells
SCALE_SHIFT, 2, each cell is 2^SCALE_SHIFT screen pixels square
ADDR_W, 13, BRAM address width (must satisfy 2^ADDR_W >= CANVAS_W*CANVAS_H)
PIX_W, 12, pixel width
CLEAR_COLOR, 12'hFFF, value written by the clear engine
BORDER_COLOR, 12'h000, border colour (optional feature only)

Ports:
clk  in  1  pixel clock; the only clock
rst  in  1  synchronous, active-high reset
valid  in  1  VGA active-video flag
h_cnt  in  10  VGA horizontal count
v_cnt  in  10  VGA vertical count
draw_req  in  1  brush write request; held until acked
draw_x  in  7  canvas cell x
draw_y  in  6  canvas cell y
draw_color  in  PIX_W  brush colour
draw_ack  out  1  one-cycle pulse: request consumed
clear_req  in  1  pulse: start clearing the canvas
clear_busy  out  1  clear engine active
mem_addr  out  ADDR_W  BRAM address
mem_we  out  1  BRAM write enable
mem_wdata  out  PIX_W  BRAM write data
mem_rdata  in  PIX_W  BRAM read data, valid 1 cycle after mem_addr
canvas_enable  out  1  current pixel lies in canvas
canvas_pixel  out  PIX_W  canvas colour

Behaviour:
- Reset: all outputs 0; FSM to IDLE; clear address 0. BRAM contents are not touched.
- In-canvas test: valid, CANVAS_X0 <= h_cnt < CANVAS_X0 + (CANVAS_W<<SCALE_SHIFT), and the same test for v.
  - cx = (h_cnt - CANVAS_X0) >> SCALE_SHIFT; cy likewise.
  - Address = cy*CANVAS_W + cx.
- Scan read slot: in-canvas and the low SCALE_SHIFT bits of (h_cnt - CANVAS_X0) are zero.
  - Drives mem_addr with the scan address and mem_we = 0.
  - The next cycle latches mem_rdata into a cell register.
  - Other in-canvas pixels reuse the cell register.
- Latency: canvas_enable and canvas_pixel are registered and appear exactly 2 clocks after the matching h_cnt/v_cnt. Out of canvas: canvas_enable = 0 and canvas_pixel = 0.
- Slot priority per cycle: scan read > clear write > draw write. A non-read cycle with no winner drives mem_we = 0.
- FSM IDLE:
  - draw_req with a free slot writes draw_color to draw_y*CANVAS_W + draw_x, with draw_ack = 1 in the same cycle.
  - Coordinates with draw_x >= CANVAS_W or draw_y >= CANVAS_H are acked without a write.
  - clear_req moves to CLEAR, with clear_busy = 1 from the next cycle.
- FSM CLEAR:
  - Each free slot writes CLEAR_COLOR at the clear address, then increments it.
  - Writing address CANVAS_W*CANVAS_H-1 returns to IDLE. clear_busy drops the cycle after that write.
  - draw_ack is held 0 for the whole clear; a pending draw_req waits.
- Simultaneous events:
  - clear_req together with draw_req: clear wins, and the draw is serviced after the clear.
  - clear_req during CLEAR restarts at address 0.
  - rst mid-clear aborts to IDLE, leaving the canvas partially cleared.
- Write slots are never lost: when scan-out holds the port, the clear or draw write simply retries on the next free cycle.

Optional Feature:
CANVAS_BORDER_EN
- Defined: pixels on the one-pixel ring just outside the canvas rectangle give canvas_enable = 1 and canvas_pixel = BORDER_COLOR. Latency is the same 2 clocks.
- Undefined: no border logic is built; the ring shows the UI layer.

Decomposition:
- Shared package holds:
  - The FSM state encoding: IDLE, CLEAR.
  - Canvas geometry constants (X0, Y0, W, H, SCALE_SHIFT, total cell count).
  - PIX_W.
- One natural sub-module: canvas_addr_map. It is purely combinational and maps h/v to the in-canvas flag, cx/cy, address and read-slot flag; the border test also lives there.
- The arbiter keeps the FSM, the slot priority and the output pipeline.

Test Plan:
- Preload BRAM[0] = 12'h0F0 and scan h = 160, v = 120 -> canvas_enable = 1 and canvas_pixel = 12'h0F0 exactly 2 clocks later, held for h = 160..163.
- draw_req at (5,3) with colour 12'hF00 while h is outside the canvas -> same-cycle draw_ack, mem_we = 1, mem_addr = 245, mem_wdata = 12'hF00.
- draw_req on a scan read slot -> no ack that cycle; ack on the next non-read cycle.
- clear_req, then let the clear run through full frames -> clear_busy is high until exactly 4800 writes of 12'hFFF to addresses 0..4799, each once. A draw_req held throughout is acked only after clear_busy falls.
- clear_req at clear address 2000, then rst at address 3000 -> first a restart at 0; after rst, clear_busy = 0 and all outputs 0 next cycle.
- draw_req at (80,0) -> draw_ack with no mem_we. With CANVAS_BORDER_EN, h = 159, v = 130 -> canvas_enable = 1 and canvas_pixel = 12'h000.
